gemv_tile_sched: RTL and testbench

- Sequencer for one gemv_subarray (32x8 MAC array) computing an arbitrary GeMV as a grid of row tiles (32 outputs each) by column tiles (8 inputs each).
- Issues weight/input buffer reads, drives the subarray enable/clear_acc/zero_in controls and flushes the accumulators.
- Presents each finished 32-row result to a downstream writeback stage through a valid/ready handshake.
- Sits between the NPU command decoder (start/config) and the compute tile.

---
 rtl/npu_ctrl_pkg.sv | 18 +
 rtl/gemv_tile_sched.sv | 159 +++++++++++++++
 tb/tb_gemv_tile_sched.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/npu_ctrl_pkg.sv
// Shared NPU control definitions: GeMV tile scheduler state encoding and
// compute-array geometry.
package npu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ACC   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_OUT   = 3'd4,
    ST_DONE  = 3'd5
  } gemv_sched_state_e;

  localparam int SA_ROWS              = 32;
  localparam int SA_COLS              = 8;
  localparam int DEFAULT_FLUSH_CYCLES = 2;

endpackage

// File: rtl/gemv_tile_sched.sv
// Sequencer for one 32x8 MAC subarray: walks row tiles x column tiles, issues
// buffer reads, flushes the MAC pipeline and hands each 32-row result to writeback.
//
// state | meaning
// IDLE  | waiting for start
// CLEAR | clear accumulators, issue read for column tile 0
// ACC   | C enable cycles, prefetching column tile k+1
// FLUSH | zero-input cycles draining the MAC pipeline
// OUT   | result presented, waiting for out_ready
// DONE  | one-cycle completion pulse
module gemv_tile_sched
  import npu_ctrl_pkg::*;
#(
  parameter int RT_W         = 8,
  parameter int CT_W         = 8,
  parameter int WADDR_W      = 16,
  parameter int FLUSH_CYCLES = DEFAULT_FLUSH_CYCLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [RT_W-1:0]    cfg_row_tiles,
  input  logic [CT_W-1:0]    cfg_col_tiles,
  output logic               busy,
  output logic               done,
  output logic               ibuf_rd_en,
  output logic [CT_W-1:0]    ibuf_rd_addr,
  output logic               wbuf_rd_en,
  output logic [WADDR_W-1:0] wbuf_rd_addr,
  output logic               sa_enable,
  output logic               sa_clear_acc,
  output logic               sa_zero_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [RT_W-1:0]    out_row_tile
);

  localparam int FL_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FL_W-1:0] FL_LAST = FL_W'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);

  gemv_sched_state_e   state_q, state_d;
  logic [RT_W-1:0]     rt_q, rt_d;
  logic [CT_W-1:0]     ct_q, ct_d;
  logic [RT_W-1:0]     r_q, r_d;
  logic [CT_W-1:0]     k_q, k_d;
  logic [FL_W-1:0]     fl_q, fl_d;
  logic [WADDR_W-1:0]  waddr_q, waddr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rt_q    <= '0;
      ct_q    <= '0;
      r_q     <= '0;
      k_q     <= '0;
      fl_q    <= '0;
      waddr_q <= '0;
    end else begin
      state_q <= state_d;
      rt_q    <= rt_d;
      ct_q    <= ct_d;
      r_q     <= r_d;
      k_q     <= k_d;
      fl_q    <= fl_d;
      waddr_q <= waddr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rt_d         = rt_q;
    ct_d         = ct_q;
    r_d          = r_q;
    k_d          = k_q;
    fl_d         = fl_q;
    waddr_d      = waddr_q;
    busy         = (state_q != ST_IDLE);
    done         = 1'b0;
    ibuf_rd_en   = 1'b0;
    ibuf_rd_addr = '0;
    wbuf_rd_en   = 1'b0;
    wbuf_rd_addr = '0;
    sa_enable    = 1'b0;
    sa_clear_acc = 1'b0;
    sa_zero_in   = 1'b0;
    out_valid    = 1'b0;
    out_row_tile = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rt_d    = cfg_row_tiles;
          ct_d    = cfg_col_tiles;
          r_d     = '0;
          k_d     = '0;
          fl_d    = '0;
          waddr_d = '0;
          state_d = (cfg_row_tiles == '0 || cfg_col_tiles == '0) ? ST_DONE : ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        sa_clear_acc = 1'b1;
        ibuf_rd_en   = 1'b1;
        wbuf_rd_en   = 1'b1;
        wbuf_rd_addr = waddr_q;
        waddr_d      = waddr_q + WADDR_W'(1);
        k_d          = '0;
        state_d      = ST_ACC;
      end
      ST_ACC: begin
        sa_enable = 1'b1;
        if (k_q == ct_q - CT_W'(1)) begin
          fl_d    = '0;
          state_d = (FLUSH_CYCLES == 0) ? ST_OUT : ST_FLUSH;
        end else begin
          // Prefetch next column tile; weight address runs on across row tiles.
          ibuf_rd_en   = 1'b1;
          ibuf_rd_addr = k_q + CT_W'(1);
          wbuf_rd_en   = 1'b1;
          wbuf_rd_addr = waddr_q;
          waddr_d      = waddr_q + WADDR_W'(1);
          k_d          = k_q + CT_W'(1);
        end
      end
      ST_FLUSH: begin
        sa_enable  = 1'b1;
        sa_zero_in = 1'b1;
        if (fl_q == FL_LAST) begin
          fl_d    = '0;
          state_d = ST_OUT;
        end else begin
          fl_d = fl_q + FL_W'(1);
        end
      end
      ST_OUT: begin
        out_valid    = 1'b1;
        out_row_tile = r_q;
        if (out_ready) begin
          if (r_q == rt_q - RT_W'(1)) begin
            state_d = ST_DONE;
          end else begin
            r_d     = r_q + RT_W'(1);
            state_d = ST_CLEAR;
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort beats any handshake in flight; IDLE ignores it so start still wins there.
    if (abort && state_q != ST_IDLE) state_d = ST_IDLE;
  end

endmodule

// File: tb/tb_gemv_tile_sched.sv
// Self-checking bench for gemv_tile_sched: a per-job schedule model predicts every
// output cycle, plus literal checks on timing, address sequences and pulse counts.
module tb_gemv_tile_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  cfg_row_tiles = '0;
  logic [7:0]  cfg_col_tiles = '0;
  logic        busy, done, ibuf_rd_en, wbuf_rd_en, sa_enable, sa_clear_acc, sa_zero_in, out_valid;
  logic [7:0]  ibuf_rd_addr, out_row_tile;
  logic [15:0] wbuf_rd_addr;

  gemv_tile_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_row_tiles(cfg_row_tiles), .cfg_col_tiles(cfg_col_tiles),
    .busy(busy), .done(done),
    .ibuf_rd_en(ibuf_rd_en), .ibuf_rd_addr(ibuf_rd_addr),
    .wbuf_rd_en(wbuf_rd_en), .wbuf_rd_addr(wbuf_rd_addr),
    .sa_enable(sa_enable), .sa_clear_acc(sa_clear_acc), .sa_zero_in(sa_zero_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_row_tile(out_row_tile)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        busy, done, ird;
    logic [7:0]  iaddr;
    logic        wrd;
    logic [15:0] waddr;
    logic        en, clr, zero, ov;
    logic [7:0]  tile;
  } obs_t;

  obs_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc_n = 0;
  int unsigned wq[$];
  int unsigned iq[$];
  int          clr_cnt, done_cnt, ov0_cnt, busy_cnt;

  function automatic obs_t sample();
    obs_t o;
    o.busy = busy; o.done = done; o.ird = ibuf_rd_en; o.iaddr = ibuf_rd_addr;
    o.wrd = wbuf_rd_en; o.waddr = wbuf_rd_addr; o.en = sa_enable; o.clr = sa_clear_acc;
    o.zero = sa_zero_in; o.ov = out_valid; o.tile = out_row_tile;
    return o;
  endfunction

  // Whole-job schedule: clear+read0, C accumulate cycles, 2 flush cycles, result slot.
  task automatic build_job(input int rr, input int cc);
    obs_t e;
    if (rr == 0 || cc == 0) begin
      e = '0; e.busy = 1; e.done = 1; exp_q.push_back(e);
      return;
    end
    for (int r = 0; r < rr; r++) begin
      e = '0; e.busy = 1; e.clr = 1; e.ird = 1; e.wrd = 1; e.waddr = 16'(r * cc);
      exp_q.push_back(e);
      for (int k = 0; k < cc; k++) begin
        e = '0; e.busy = 1; e.en = 1;
        if (k < cc - 1) begin
          e.ird = 1; e.iaddr = 8'(k + 1); e.wrd = 1; e.waddr = 16'(r * cc + k + 1);
        end
        exp_q.push_back(e);
      end
      for (int f = 0; f < 2; f++) begin
        e = '0; e.busy = 1; e.en = 1; e.zero = 1; exp_q.push_back(e);
      end
      e = '0; e.busy = 1; e.ov = 1; e.tile = 8'(r); exp_q.push_back(e);
    end
    e = '0; e.busy = 1; e.done = 1; exp_q.push_back(e);
  endtask

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  // One clock: compare at negedge against the model, advance the model, return at posedge+1.
  task automatic step();
    obs_t act, ex;
    @(negedge clk);
    cyc_n++;
    act = sample();
    ex = (rst_n && exp_q.size() != 0) ? exp_q[0] : '0;
    n_checks++;
    if (act !== ex) begin
      n_fail++;
      $display("FAIL cycle_check cyc=%0d actual=%h required=%h", cyc_n, act, ex);
    end
    if (wbuf_rd_en) wq.push_back(int'(wbuf_rd_addr));
    if (ibuf_rd_en) iq.push_back(int'(ibuf_rd_addr));
    if (sa_clear_acc) clr_cnt++;
    if (done) done_cnt++;
    if (out_valid && out_row_tile == 0) ov0_cnt++;
    if (busy) busy_cnt++;
    if (!rst_n) exp_q.delete();
    else if (exp_q.size() == 0) begin
      if (start) build_job(int'(cfg_row_tiles), int'(cfg_col_tiles));
    end else if (abort) exp_q.delete();
    else if (!exp_q[0].ov || out_ready) void'(exp_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wq.delete(); iq.delete();
    clr_cnt = 0; done_cnt = 0; ov0_cnt = 0; busy_cnt = 0;
  endtask

  task automatic launch(input int rr, input int cc);
    cfg_row_tiles = 8'(rr); cfg_col_tiles = 8'(cc); start = 1;
    step();
    start = 0;
  endtask

  task automatic run_to_idle(input int budget);
    int b = 0;
    while (exp_q.size() != 0 && b < budget) begin
      step(); b++;
    end
    check("job_timeout", (b >= budget) ? 1 : 0, 0);
  endtask

  function automatic logic [5:0] sig();
    return {sa_clear_acc, sa_enable, sa_zero_in, out_valid, done, wbuf_rd_en};
  endfunction

  initial begin
    logic [5:0] lit1 [7];
    int b;
    lit1 = '{6'b000000, 6'b100001, 6'b010000, 6'b011000, 6'b011000, 6'b000100, 6'b000010};
    clear_mon();
    #1;
    check("reset_busy", busy, 0);
    check("reset_outputs", {done, ibuf_rd_en, wbuf_rd_en, sa_enable, sa_clear_acc, out_valid}, 0);
    step(); step();
    rst_n = 1;
    step();

    // R=1 C=1, ready high: literal cycle-by-cycle timeline
    out_ready = 1;
    cfg_row_tiles = 1; cfg_col_tiles = 1; start = 1;
    check("t1_c0", sig(), lit1[0]);
    step(); start = 0;
    for (int i = 1; i < 7; i++) begin
      check($sformatf("t1_c%0d", i), sig(), lit1[i]);
      step();
    end
    check("t1_idle", busy, 0);

    // R=3 C=4: contiguous weight addresses, repeating input addresses
    clear_mon();
    launch(3, 4);
    run_to_idle(200);
    check("t2_wcount", wq.size(), 12);
    for (int i = 0; i < 12 && i < wq.size(); i++) check("t2_waddr", wq[i], i);
    for (int i = 0; i < 12 && i < iq.size(); i++) check("t2_iaddr", iq[i], i % 4);
    check("t2_clears", clr_cnt, 3);
    check("t2_dones", done_cnt, 1);

    // R=2 C=2, out_ready low for 5 cycles in the first result slot
    clear_mon();
    out_ready = 0;
    launch(2, 2);
    b = 0;
    while (!out_valid && b < 50) begin step(); b++; end
    for (int i = 0; i < 5; i++) step();
    out_ready = 1;
    run_to_idle(100);
    check("t3_hold_cycles", ov0_cnt, 6);
    check("t3_busy_cycles", busy_cnt, 2 * 6 + 5 + 1);

    // Abort in ACC of tile 1, then a clean R=1 C=1 job
    clear_mon();
    launch(4, 8);
    b = 0;
    while (!(sa_enable && !sa_zero_in && wbuf_rd_en && wbuf_rd_addr == 16'd11) && b < 100) begin
      step(); b++;
    end
    check("t4_reach_acc", (b < 100) ? 1 : 0, 1);
    abort = 1;
    step();
    abort = 0;
    check("t4_busy", busy, 0);
    check("t4_outputs", {ibuf_rd_en, wbuf_rd_en, sa_enable, out_valid, done}, 0);
    step();
    check("t4_no_done", done_cnt, 0);
    clear_mon();
    launch(1, 1);
    run_to_idle(50);
    check("t4_restart_waddr", (wq.size() > 0) ? wq[0] : 32'hFFFF, 0);
    check("t4_restart_done", done_cnt, 1);

    // C=0: straight to DONE, no reads or enables
    clear_mon();
    cfg_row_tiles = 5; cfg_col_tiles = 0; start = 1;
    step(); start = 0;
    check("t5_done_pulse", done, 1);
    step();
    check("t5_reads", wq.size() + iq.size(), 0);
    check("t5_busy_cycles", busy_cnt, 1);

    // start held with changed config during a running job is ignored
    clear_mon();
    launch(2, 3);
    start = 1; cfg_row_tiles = 7; cfg_col_tiles = 9;
    b = 0;
    while (exp_q.size() != 0 && b < 40) begin step(); b++; end
    start = 0;
    check("t5_job_len", busy_cnt, 2 * 7 + 1);

    // Asynchronous reset inside FLUSH
    launch(2, 2);
    b = 0;
    while (!sa_zero_in && b < 20) begin step(); b++; end
    #2 rst_n = 0;
    #1;
    check("t6_async_busy", busy, 0);
    check("t6_async_outputs", {sa_enable, sa_zero_in, out_valid, done}, 0);
    step();
    rst_n = 1;
    step();
    check("t6_idle_after", busy, 0);

    // Randomized jobs with stalls, aborts, stray starts and config churn
    for (int j = 0; j < 25; j++) begin
      abort = ($urandom_range(0, 3) == 0);
      launch($urandom_range(0, 4), $urandom_range(0, 6));
      abort = 0;
      b = 0;
      while (exp_q.size() != 0 && b < 2000) begin
        out_ready = $urandom_range(0, 1);
        abort = ($urandom_range(0, 39) == 0);
        start = ($urandom_range(0, 7) == 0);
        cfg_row_tiles = 8'($urandom_range(0, 255));
        cfg_col_tiles = 8'($urandom_range(0, 255));
        step();
        b++;
      end
      abort = 0; start = 0;
      check("rand_timeout", (b >= 2000) ? 1 : 0, 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
